// File: rtl/hsv_core_pkg.sv
// hsv_core_pkg: shared widths, unit indices and retire-path types for the commit join.
package hsv_core_pkg;
    localparam int NUM_UNITS = 5;
    localparam int TOKEN_W = 8;
    localparam int XLEN = 32;
    localparam int REG_N = 32;
    localparam int RD_W = 5;
    localparam int UNIT_ALU = 0;
    localparam int UNIT_FOO = 1;
    localparam int UNIT_MEM = 2;
    localparam int UNIT_BRANCH = 3;
    localparam int UNIT_CTRL_STATUS = 4;
    typedef struct packed {
        logic valid;
        logic [TOKEN_W-1:0] token;
        logic [RD_W-1:0] rd_addr;
        logic [XLEN-1:0] rd_value;
        logic writeback;
        logic redirect;
        logic [XLEN-1:0] target;
    } commit_unit_t;
    typedef struct packed {
        logic wr_en;
        logic [RD_W-1:0] wr_addr;
        logic [XLEN-1:0] wr_data;
        logic [REG_N-1:0] commit_mask;
        logic flush_req;
        logic [XLEN-1:0] flush_target;
    } commit_data_t;
    function automatic logic [REG_N-1:0] rd_onehot(input logic [RD_W-1:0] rd);
        return REG_N'(1) << rd;
    endfunction
endpackage

// File: rtl/hsv_core_commit_join_if.sv
// hsv_core_commit_join_if: execution-unit results in, register-file writes and flush out.
interface hsv_core_commit_join_if;
    import hsv_core_pkg::*;
    logic [NUM_UNITS-1:0] unit_valid;
    logic [NUM_UNITS*TOKEN_W-1:0] unit_token;
    logic [NUM_UNITS*RD_W-1:0] unit_rd_addr;
    logic [NUM_UNITS*XLEN-1:0] unit_rd_value;
    logic [NUM_UNITS-1:0] unit_writeback;
    logic [NUM_UNITS-1:0] unit_redirect;
    logic [NUM_UNITS*XLEN-1:0] unit_target;
    logic [NUM_UNITS-1:0] unit_stall;
    logic wr_en;
    logic [RD_W-1:0] wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [REG_N-1:0] commit_mask;
    logic flush_req;
    logic [XLEN-1:0] flush_target;
    logic order_error;
    modport master (
        output unit_valid, unit_token, unit_rd_addr, unit_rd_value, unit_writeback, unit_redirect, unit_target,
        input unit_stall, wr_en, wr_addr, wr_data, commit_mask, flush_req, flush_target, order_error
    );
    modport slave (
        input unit_valid, unit_token, unit_rd_addr, unit_rd_value, unit_writeback, unit_redirect, unit_target,
        output unit_stall, wr_en, wr_addr, wr_data, commit_mask, flush_req, flush_target, order_error
    );
endinterface

// File: rtl/hsv_core_commit_slot.sv
// hsv_core_commit_slot: one-entry holding buffer for a single execution unit's result.
module hsv_core_commit_slot
    import hsv_core_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  commit_unit_t unit,
    input  logic         sel,
    input  logic         clear,
    input  logic         block,
    output commit_unit_t entry,
    output logic         stall
);
    logic load;
    // A slot draining this cycle accepts its successor at the same edge.
    assign stall = entry.valid & ~sel & ~block;
    assign load = unit.valid & ~stall & ~block & ~clear;
    always_ff @(posedge clk) begin
        if (rst || clear)
            entry <= '0;
        else if (load)
            entry <= unit;
        else if (sel)
            entry.valid <= 1'b0;
    end
endmodule

// File: rtl/hsv_core_commit_join.sv
// hsv_core_commit_join: retires buffered unit results in token order and raises flushes.
module hsv_core_commit_join
    import hsv_core_pkg::*;
(
    input logic clk_core,
    input logic rst_core,
    hsv_core_commit_join_if.slave bus
);
    commit_unit_t unit [NUM_UNITS];
    commit_unit_t entry [NUM_UNITS];
    logic [NUM_UNITS-1:0] match, sel, stall;
    logic [TOKEN_W-1:0] expected_token;
    logic [RD_W-1:0] sel_rd;
    logic [XLEN-1:0] sel_value, sel_target;
    logic sel_wb, sel_redirect, any_sel, flush_now, multi, wr, order_error;
    commit_data_t retire, retire_d;
    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_slot
        assign unit[i] = '{
            valid: bus.unit_valid[i],
            token: bus.unit_token[i*TOKEN_W +: TOKEN_W],
            rd_addr: bus.unit_rd_addr[i*RD_W +: RD_W],
            rd_value: bus.unit_rd_value[i*XLEN +: XLEN],
            writeback: bus.unit_writeback[i],
            redirect: bus.unit_redirect[i],
            target: bus.unit_target[i*XLEN +: XLEN]
        };
        hsv_core_commit_slot u_slot (
            .clk(clk_core), .rst(rst_core), .unit(unit[i]), .sel(sel[i]),
            .clear(flush_now), .block(retire.flush_req), .entry(entry[i]), .stall(stall[i])
        );
        assign match[i] = entry[i].valid && entry[i].token == expected_token;
    end
    // Lowest matching index wins; more than one match is a protocol violation.
    assign multi = |(match & (match - NUM_UNITS'(1)));
    assign any_sel = |match;
    always_comb begin
        sel = match & (~match + NUM_UNITS'(1));
        sel_rd = '0;
        sel_value = '0;
        sel_target = '0;
        sel_wb = 1'b0;
        sel_redirect = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (sel[k]) begin
                sel_rd = entry[k].rd_addr;
                sel_value = entry[k].rd_value;
                sel_target = entry[k].target;
                sel_wb = entry[k].writeback;
                sel_redirect = entry[k].redirect;
            end
        end
    end
    assign flush_now = any_sel & sel_redirect;
    assign wr = any_sel & sel_wb & (sel_rd != '0);
    always_comb begin
        retire_d.wr_en = wr;
        retire_d.wr_addr = wr ? sel_rd : '0;
        retire_d.wr_data = wr ? sel_value : '0;
        retire_d.commit_mask = wr ? rd_onehot(sel_rd) : '0;
        retire_d.flush_req = flush_now;
        retire_d.flush_target = flush_now ? sel_target : '0;
    end
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            retire <= '0;
            expected_token <= '0;
            order_error <= 1'b0;
        end else begin
            retire <= retire_d;
            order_error <= order_error | multi;
            if (flush_now)
                expected_token <= '0;
            else if (any_sel)
                expected_token <= expected_token + TOKEN_W'(1);
        end
    end
    assign bus.unit_stall = stall;
    assign bus.wr_en = retire.wr_en;
    assign bus.wr_addr = retire.wr_addr;
    assign bus.wr_data = retire.wr_data;
    assign bus.commit_mask = retire.commit_mask;
    assign bus.flush_req = retire.flush_req;
    assign bus.flush_target = retire.flush_target;
    assign bus.order_error = order_error;
endmodule

// File: tb/tb_hsv_core_commit_join.sv
// tb_hsv_core_commit_join: directed stimulus with a retire-order scoreboard.
module tb_hsv_core_commit_join;
    import hsv_core_pkg::*;
    logic clk_core = 1'b0;
    logic rst_core = 1'b1;
    always #5 clk_core = ~clk_core;
    hsv_core_commit_join_if bus();
    hsv_core_commit_join dut (.clk_core(clk_core), .rst_core(rst_core), .bus(bus));
    commit_data_t exp_q[$];
    int vectors = 0;
    int errors = 0;
    logic [NUM_UNITS-1:0] acc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic commit_data_t obs_rec();
        return '{wr_en: bus.wr_en, wr_addr: bus.wr_addr, wr_data: bus.wr_data,
                 commit_mask: bus.commit_mask, flush_req: bus.flush_req, flush_target: bus.flush_target};
    endfunction

    task automatic push(input int rd, input logic [31:0] val, input logic fl, input logic [31:0] tgt);
        commit_data_t r;
        r.wr_en = rd != 0;
        r.wr_addr = (rd != 0) ? RD_W'(rd) : '0;
        r.wr_data = (rd != 0) ? val : '0;
        r.commit_mask = (rd != 0) ? (32'd1 << rd) : '0;
        r.flush_req = fl;
        r.flush_target = fl ? tgt : '0;
        exp_q.push_back(r);
    endtask

    // One clock: note handshakes before the edge, then check retire output after it.
    task automatic tick();
        #1 acc = bus.unit_valid & ~bus.unit_stall & {NUM_UNITS{~bus.flush_req}};
        @(posedge clk_core);
        @(negedge clk_core);
        bus.unit_valid = bus.unit_valid & ~acc;
        if (bus.wr_en || bus.flush_req) begin
            if (exp_q.size() == 0)
                chk("spurious_retire", 128'(obs_rec()), 128'(0));
            else
                chk("retire", 128'(obs_rec()), 128'(exp_q.pop_front()));
        end
    endtask

    task automatic send(input int u, input int tok, input int rd, input logic [31:0] val,
                        input logic wb, input logic redir, input logic [31:0] tgt);
        bus.unit_valid[u] = 1'b1;
        bus.unit_token[u*TOKEN_W +: TOKEN_W] = TOKEN_W'(tok);
        bus.unit_rd_addr[u*RD_W +: RD_W] = RD_W'(rd);
        bus.unit_rd_value[u*XLEN +: XLEN] = val;
        bus.unit_writeback[u] = wb;
        bus.unit_redirect[u] = redir;
        bus.unit_target[u*XLEN +: XLEN] = tgt;
    endtask

    task automatic do_reset();
        rst_core = 1'b1;
        bus.unit_valid = '0;
        tick();
        tick();
        rst_core = 1'b0;
        exp_q.delete();
        chk("reset_retire", 128'(obs_rec()), 128'(0));
        chk("reset_stall", 128'(bus.unit_stall), 128'(0));
        chk("reset_order_error", 128'(bus.order_error), 128'(0));
    endtask

    initial begin
        bus.unit_valid = '0;
        bus.unit_token = '0;
        bus.unit_rd_addr = '0;
        bus.unit_rd_value = '0;
        bus.unit_writeback = '0;
        bus.unit_redirect = '0;
        bus.unit_target = '0;
        // Basic retire, then token 1 proves expected_token advanced.
        do_reset();
        send(UNIT_ALU, 0, 5, 32'h1234, 1, 0, 0);
        push(5, 32'h1234, 0, 0);
        tick();
        tick();
        chk("first_commit_mask", 128'(bus.commit_mask), 128'(32'h20));
        send(UNIT_ALU, 1, 6, 32'h55, 1, 0, 0);
        push(6, 32'h55, 0, 0);
        tick();
        tick();
        chk("drained_basic", 128'(exp_q.size()), 128'(0));
        // Out-of-order completion.
        do_reset();
        send(UNIT_MEM, 1, 3, 32'hAAAA, 1, 0, 0);
        push(4, 32'hBBBB, 0, 0);
        push(3, 32'hAAAA, 0, 0);
        tick();
        chk("mem_stall_wait", 128'(bus.unit_stall[UNIT_MEM]), 128'(1));
        send(UNIT_ALU, 0, 4, 32'hBBBB, 1, 0, 0);
        tick();
        chk("mem_stall_alu_sel", 128'(bus.unit_stall[UNIT_MEM]), 128'(1));
        tick();
        chk("mem_stall_released", 128'(bus.unit_stall[UNIT_MEM]), 128'(0));
        tick();
        chk("drained_ooo", 128'(exp_q.size()), 128'(0));
        // Write to x0 still consumes a token.
        do_reset();
        send(UNIT_ALU, 0, 0, 32'hDEAD, 1, 0, 0);
        tick();
        tick();
        chk("x0_wr_en", 128'(bus.wr_en), 128'(0));
        chk("x0_mask", 128'(bus.commit_mask), 128'(0));
        send(UNIT_ALU, 1, 7, 32'h77, 1, 0, 0);
        push(7, 32'h77, 0, 0);
        tick();
        tick();
        chk("drained_x0", 128'(exp_q.size()), 128'(0));
        // Redirect flushes younger work and restarts tokens at 0.
        do_reset();
        send(UNIT_ALU, 0, 2, 32'h20, 1, 0, 0);
        push(2, 32'h20, 0, 0);
        tick();
        send(UNIT_ALU, 1, 3, 32'h30, 1, 0, 0);
        push(3, 32'h30, 0, 0);
        tick();
        tick();
        send(UNIT_BRANCH, 2, 1, 32'h8000001C, 1, 1, 32'h80000040);
        send(UNIT_FOO, 3, 9, 32'h99, 1, 0, 0);
        push(1, 32'h8000001C, 1, 32'h80000040);
        tick();
        tick();
        chk("flush_req", 128'(bus.flush_req), 128'(1));
        tick();
        chk("flush_pulse", 128'(bus.flush_req), 128'(0));
        chk("foo_cleared", 128'(bus.unit_stall), 128'(0));
        send(UNIT_ALU, 0, 8, 32'h88, 1, 0, 0);
        push(8, 32'h88, 0, 0);
        tick();
        tick();
        chk("drained_flush", 128'(exp_q.size()), 128'(0));
        // Token wrap at full rate.
        do_reset();
        for (int k = 0; k <= 256; k++) begin
            send(UNIT_ALU, k % 256, 1 + k % 31, 32'h1000 + k, 1, 0, 0);
            push(1 + k % 31, 32'h1000 + k, 0, 0);
            tick();
            chk("wrap_accept", 128'(acc[UNIT_ALU]), 128'(1));
            if (k > 0) chk("wrap_no_bubble", 128'(bus.wr_en), 128'(1));
        end
        tick();
        chk("drained_wrap", 128'(exp_q.size()), 128'(0));
        // Duplicate token: lowest index retires, error is sticky.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            send(UNIT_ALU, k, 2, 32'h700 + k, 1, 0, 0);
            push(2, 32'h700 + k, 0, 0);
            tick();
        end
        send(UNIT_ALU, 7, 10, 32'hA7, 1, 0, 0);
        send(UNIT_MEM, 7, 11, 32'hB7, 1, 0, 0);
        push(10, 32'hA7, 0, 0);
        tick();
        tick();
        chk("dup_order_error", 128'(bus.order_error), 128'(1));
        tick();
        tick();
        tick();
        chk("dup_error_sticky", 128'(bus.order_error), 128'(1));
        chk("dup_mem_stuck", 128'(bus.unit_stall[UNIT_MEM]), 128'(1));
        chk("drained_dup", 128'(exp_q.size()), 128'(0));
        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
